// File: rtl/dmem_pkg.sv
// Shared types and lane helpers for the RV32 data-memory controller.
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte enables for a store of the given width at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] off);
    logic [3:0] m;
    case (funct3)
      F3_B, F3_BU: m = 4'b0001 << off;
      F3_H, F3_HU: m = 4'b0011 << off;
      default:     m = 4'b1111;
    endcase
    return m;
  endfunction

  // Pick the addressed byte/half out of a word and sign- or zero-extend it.
  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] sh;
    logic [31:0] r;
    sh = word >> {off, 3'b000};
    case (funct3)
      F3_B:    r = {{24{sh[7]}}, sh[7:0]};
      F3_BU:   r = {24'h0, sh[7:0]};
      F3_H:    r = {{16{sh[15]}}, sh[15:0]};
      F3_HU:   r = {16'h0, sh[15:0]};
      F3_W:    r = word;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // Halfwords need an even offset, words a zero offset.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
    logic m;
    case (funct3)
      F3_H, F3_HU: m = off[0];
      F3_W:        m = (off != 2'b00);
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised storage with per-byte write enables and a registered read port.
module byte_lane_ram #(
  parameter int WORD_AW   = 7,
  parameter     INIT_FILE = ""
) (
  input  logic               clk,
  input  logic [3:0]         we,
  input  logic               re,
  input  logic [WORD_AW-1:0] addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_d;
  logic [31:0] rdata_q;

  // Read data only moves when a read is requested, so it holds between loads.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[addr];
  end

  // Byte-lane writes and the read register.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// RV32 data-memory controller: valid/ready request, optional wait states,
// sub-word lane steering and misaligned/illegal-op fault responses.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 9,
  parameter int WAIT_STATES   = 0,
  parameter     INIT_FILE     = ""
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ReqValid,
  output logic                     ReqReady,
  input  logic                     MemRead,
  input  logic                     MemWrite,
  input  logic [2:0]               Funct3,
  input  logic [ADDRESS_WIDTH-1:0] Address,
  input  logic [31:0]              WriteData,
  output logic                     RespValid,
  output logic [31:0]              ReadData,
  output logic                     Fault
);

  // Handshake: a request is taken on a rising edge where ReqValid and ReqReady
  // are both high and it is a load or a store; ReqReady is high only in IDLE
  // and never while reset is asserted. RespValid is a one-cycle strobe.

  localparam int         WORD_AW   = ADDRESS_WIDTH - 2;
  localparam logic [3:0] LAST_WAIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_e                   state_q, state_d;
  logic [3:0]               wait_cnt_q, wait_cnt_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     fault_q, fault_d;
  logic                     resp_load_q, resp_load_d;
  logic [2:0]               ext_f3_q, ext_f3_d;
  logic [1:0]               ext_off_q, ext_off_d;
  logic                     cap_rd_q, cap_rd_d;
  logic                     cap_wr_q, cap_wr_d;
  logic [2:0]               cap_f3_q, cap_f3_d;
  logic [ADDRESS_WIDTH-1:0] cap_addr_q, cap_addr_d;
  logic [31:0]              cap_wdata_q, cap_wdata_d;

  logic                     req_ready, accept, commit;
  logic                     req_rd, req_wr, req_fault;
  logic [2:0]               req_f3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [31:0]              req_wdata;
  logic [3:0]               ram_we;
  logic                     ram_re;
  logic [31:0]              ram_wdata, ram_rdata;

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept    = ReqValid && req_ready && (MemRead || MemWrite);

  // With no wait states the access commits on the accept edge itself, so it
  // uses the live inputs; otherwise it uses the copy captured at accept.
  assign req_rd    = (WAIT_STATES == 0) ? MemRead   : cap_rd_q;
  assign req_wr    = (WAIT_STATES == 0) ? MemWrite  : cap_wr_q;
  assign req_f3    = (WAIT_STATES == 0) ? Funct3    : cap_f3_q;
  assign req_addr  = (WAIT_STATES == 0) ? Address   : cap_addr_q;
  assign req_wdata = (WAIT_STATES == 0) ? WriteData : cap_wdata_q;
  assign commit    = (WAIT_STATES == 0) ? accept
                                        : (state_q == WAIT) && (wait_cnt_q == LAST_WAIT);

  // Fault classification and lane steering for the committing request.
  always_comb begin
    req_fault = (req_rd && req_wr)
             || (req_rd && (req_f3 == 3'b011 || req_f3 == 3'b110 || req_f3 == 3'b111))
             || (req_wr && (req_f3[2] || req_f3 == 3'b011))
             || is_misaligned(req_f3, req_addr[1:0]);
    case (req_f3[1:0])
      2'b00:   ram_wdata = {4{req_wdata[7:0]}};
      2'b01:   ram_wdata = {2{req_wdata[15:0]}};
      default: ram_wdata = req_wdata;
    endcase
    ram_we = 4'b0000;
    ram_re = 1'b0;
    if (commit && !req_fault && !reset) begin
      if (req_wr) ram_we = lane_mask(req_f3, req_addr[1:0]);
      if (req_rd) ram_re = 1'b1;
    end
  end

  // Next-state logic: IDLE -> WAIT (skipped when no wait states) -> RESP -> IDLE.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    resp_valid_d = 1'b0;
    fault_d      = fault_q;
    resp_load_d  = resp_load_q;
    ext_f3_d     = ext_f3_q;
    ext_off_d    = ext_off_q;
    cap_rd_d     = cap_rd_q;
    cap_wr_d     = cap_wr_q;
    cap_f3_d     = cap_f3_q;
    cap_addr_d   = cap_addr_q;
    cap_wdata_d  = cap_wdata_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d    = (WAIT_STATES == 0) ? RESP : WAIT;
        wait_cnt_d = 4'd0;
      end
      WAIT: if (wait_cnt_q == LAST_WAIT) state_d = RESP;
            else                         wait_cnt_d = wait_cnt_q + 4'd1;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      cap_rd_d    = MemRead;
      cap_wr_d    = MemWrite;
      cap_f3_d    = Funct3;
      cap_addr_d  = Address;
      cap_wdata_d = WriteData;
    end
    if (commit) begin
      resp_valid_d = 1'b1;
      fault_d      = req_fault;
      resp_load_d  = req_rd && !req_fault;
      ext_f3_d     = req_f3;
      ext_off_d    = req_addr[1:0];
    end
  end

  // State and response registers; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wait_cnt_q   <= 4'd0;
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      resp_load_q  <= 1'b0;
      ext_f3_q     <= 3'd0;
      ext_off_q    <= 2'd0;
      cap_rd_q     <= 1'b0;
      cap_wr_q     <= 1'b0;
      cap_f3_q     <= 3'd0;
      cap_addr_q   <= '0;
      cap_wdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      resp_valid_q <= resp_valid_d;
      fault_q      <= fault_d;
      resp_load_q  <= resp_load_d;
      ext_f3_q     <= ext_f3_d;
      ext_off_q    <= ext_off_d;
      cap_rd_q     <= cap_rd_d;
      cap_wr_q     <= cap_wr_d;
      cap_f3_q     <= cap_f3_d;
      cap_addr_q   <= cap_addr_d;
      cap_wdata_q  <= cap_wdata_d;
    end
  end

  byte_lane_ram #(
    .WORD_AW   (WORD_AW),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (req_addr[ADDRESS_WIDTH-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign ReqReady  = req_ready;
  assign RespValid = resp_valid_q;
  assign Fault     = fault_q;
  assign ReadData  = resp_load_q ? load_extend(ext_f3_q, ext_off_q, ram_rdata) : 32'h0;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: instance 0 has no wait states, instance 1 has three.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        rv [2];
  logic        rdy [2];
  logic        mr [2];
  logic        mw [2];
  logic [2:0]  rf3 [2];
  logic [8:0]  rad [2];
  logic [31:0] rwd [2];
  logic        rsp [2];
  logic [31:0] rdat [2];
  logic        flt [2];

  logic [7:0]  mb0 [512];
  logic [7:0]  mb1 [512];
  logic [32:0] exp_q0[$], exp_q1[$];
  int          ecyc_q0[$], ecyc_q1[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  int          last_acc [2];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  data_memory_ctrl #(.ADDRESS_WIDTH(9), .WAIT_STATES(0), .INIT_FILE("")) u0 (
    .clk(clk), .reset(rst[0]), .ReqValid(rv[0]), .ReqReady(rdy[0]), .MemRead(mr[0]),
    .MemWrite(mw[0]), .Funct3(rf3[0]), .Address(rad[0]), .WriteData(rwd[0]),
    .RespValid(rsp[0]), .ReadData(rdat[0]), .Fault(flt[0]));

  data_memory_ctrl #(.ADDRESS_WIDTH(9), .WAIT_STATES(3), .INIT_FILE("")) u1 (
    .clk(clk), .reset(rst[1]), .ReqValid(rv[1]), .ReqReady(rdy[1]), .MemRead(mr[1]),
    .MemWrite(mw[1]), .Funct3(rf3[1]), .Address(rad[1]), .WriteData(rwd[1]),
    .RespValid(rsp[1]), .ReadData(rdat[1]), .Fault(flt[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [7:0] mget(int s, int a);
    return (s == 0) ? mb0[a] : mb1[a];
  endfunction

  function automatic logic [32:0] model(int s, logic rd, logic wr, logic [2:0] f3,
                                        logic [8:0] a, logic [31:0] d);
    int          size;
    logic        bad;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    bad  = 1'b0;
    if (rd && wr) bad = 1'b1;
    else if (rd && (f3 == 3 || f3 == 6 || f3 == 7)) bad = 1'b1;
    else if (wr && f3 > 2) bad = 1'b1;
    if ((int'(a) % size) != 0) bad = 1'b1;
    if (bad) return {1'b1, 32'h0};
    if (wr) begin
      for (int i = 0; i < size; i++) begin
        if (s == 0) mb0[int'(a) + i] = d[8*i +: 8];
        else        mb1[int'(a) + i] = d[8*i +: 8];
      end
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int i = 0; i < size; i++) v = v | ({24'h0, mget(s, int'(a) + i)} << (8 * i));
    if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
    return {1'b0, v};
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input int s, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [8:0] a, input logic [31:0] d, input bit expect_resp);
    int          n;
    int          w;
    logic [32:0] e;
    w = (s == 0) ? 0 : 3;
    @(negedge clk);
    n = 0;
    while (!rdy[s] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk("accept_timeout", 64'd0, 64'd1);
      return;
    end
    rv[s] = 1'b1; mr[s] = rd; mw[s] = wr; rf3[s] = f3; rad[s] = a; rwd[s] = d;
    if (!rd && !wr) begin
      @(negedge clk);
      chk("noop_ignored_ready", 64'(rdy[s]), 64'd1);
    end else begin
      if (expect_resp) begin
        e = model(s, rd, wr, f3, a, d);
        if (s == 0) begin exp_q0.push_back(e); ecyc_q0.push_back(cyc + 1 + w); end
        else        begin exp_q1.push_back(e); ecyc_q1.push_back(cyc + 1 + w); end
      end
      last_acc[s] = cyc + 1;
      @(negedge clk);
    end
    // Scramble inputs after acceptance; the controller must ignore them.
    rv[s] = 1'b0; mr[s] = 1'($urandom); mw[s] = 1'($urandom); rf3[s] = 3'($urandom);
    rad[s] = 9'($urandom); rwd[s] = $urandom;
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic check_resp(input int s);
    logic [32:0] e;
    int          c;
    if ((s == 0 && exp_q0.size() == 0) || (s == 1 && exp_q1.size() == 0)) begin
      chk($sformatf("unexpected_resp%0d", s), 64'd1, 64'd0);
      return;
    end
    if (s == 0) begin e = exp_q0.pop_front(); c = ecyc_q0.pop_front(); end
    else        begin e = exp_q1.pop_front(); c = ecyc_q1.pop_front(); end
    chk($sformatf("resp_data%0d", s), 64'({flt[s], rdat[s]}), 64'(e));
    chk($sformatf("resp_cycle%0d", s), 64'(cyc), 64'(c));
  endtask

  always @(negedge clk) begin
    if (rsp[0]) check_resp(0);
    if (rsp[1]) check_resp(1);
  end

  // ---------------- stimulus ----------------
  task automatic rand_op(input int s, input int lo, input int hi);
    int         r;
    int         size;
    logic       rd, wr;
    logic [2:0] f3;
    logic [8:0] a;
    logic [2:0] legal [5];
    legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    r  = $urandom_range(0, 19);
    rd = (r == 1) || (r >= 2 && r <= 10);
    wr = (r == 1) || (r > 10);
    f3 = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 4)] : 3'($urandom);
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    a  = 9'($urandom_range(lo, hi));
    if ($urandom_range(0, 9) < 7) a = a & ~9'(size - 1);
    issue(s, rd, wr, f3, a, $urandom, 1'b1);
  endtask

  initial begin
    int t0;
    int n;
    for (int s = 0; s < 2; s++) begin
      rst[s] = 1'b1; rv[s] = 1'b0; mr[s] = 1'b0; mw[s] = 1'b0;
      rf3[s] = 3'd0; rad[s] = 9'd0; rwd[s] = 32'd0; last_acc[s] = 0;
    end
    repeat (3) @(negedge clk);
    chk("ready_in_reset0", 64'(rdy[0]), 64'd0);
    chk("ready_in_reset1", 64'(rdy[1]), 64'd0);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", 64'(rdy[s]), 64'd1);
      chk("reset_resp", 64'({rsp[s], flt[s], rdat[s]}), 64'd0);
    end

    // Make every word of instance 0 known.
    for (int w = 0; w < 128; w++) issue(0, 1'b0, 1'b1, 3'b010, 9'(w * 4), $urandom, 1'b1);

    // Directed cases, no wait states.
    issue(0, 1'b0, 1'b1, 3'b010, 9'h010, 32'hDEAD_BEEF, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 1'b1);
    chk("lw_model_deadbeef", 64'(exp_q0.size()), 64'd1);
    issue(0, 1'b0, 1'b1, 3'b010, 9'h010, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, 3'b000, 9'h013, 32'h0000_0080, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b000, 9'h013, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b100, 9'h013, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b010, 9'h010, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, 3'b010, 9'h020, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, 3'b001, 9'h022, 32'h0000_1234, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b101, 9'h022, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b010, 9'h011, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, 3'b001, 9'h023, 32'hFFFF_FFFF, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 1'b1);
    issue(0, 1'b1, 1'b1, 3'b010, 9'h020, 32'h5555_5555, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b011, 9'h020, 32'h0, 1'b1);
    issue(0, 1'b0, 1'b1, 3'b100, 9'h020, 32'h7777_7777, 1'b1);
    issue(0, 1'b0, 1'b0, 3'b010, 9'h020, 32'h6666_6666, 1'b1);
    issue(0, 1'b1, 1'b0, 3'b010, 9'h020, 32'h0, 1'b1);
    t0 = last_acc[0];
    issue(0, 1'b1, 1'b0, 3'b000, 9'h021, 32'h0, 1'b1);
    chk("throughput_w0", 64'(last_acc[0] - t0), 64'd2);

    for (int i = 0; i < 400; i++) rand_op(0, 0, 511);

    // Wait-state instance: seed a small region.
    issue(1, 1'b0, 1'b1, 3'b010, 9'h040, 32'h1111_1111, 1'b1);
    for (int w = 0; w < 4; w++) issue(1, 1'b0, 1'b1, 3'b010, 9'(9'h060 + w * 4), $urandom, 1'b1);

    // Busy window and back-to-back spacing with three wait states.
    issue(1, 1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 1'b1);
    t0 = last_acc[1];
    for (int k = 0; k < 4; k++) begin
      chk("busy_ready_low", 64'(rdy[1]), 64'd0);
      @(negedge clk);
    end
    chk("ready_after_resp", 64'(rdy[1]), 64'd1);
    issue(1, 1'b1, 1'b0, 3'b100, 9'h041, 32'h0, 1'b1);
    t0 = last_acc[1];
    issue(1, 1'b1, 1'b0, 3'b101, 9'h042, 32'h0, 1'b1);
    chk("throughput_w3", 64'(last_acc[1] - t0), 64'd5);

    // Store dropped by reset two cycles after acceptance.
    issue(1, 1'b0, 1'b1, 3'b010, 9'h040, 32'h2222_2222, 1'b0);
    @(negedge clk);
    rst[1] = 1'b1;
    @(negedge clk);
    chk("ready_low_reset_mid", 64'(rdy[1]), 64'd0);
    @(negedge clk);
    rst[1] = 1'b0;
    repeat (6) @(negedge clk);
    chk("ready_after_mid_reset", 64'(rdy[1]), 64'd1);
    issue(1, 1'b1, 1'b0, 3'b010, 9'h040, 32'h0, 1'b1);

    for (int i = 0; i < 40; i++) rand_op(1, 9'h060, 9'h06F);

    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_q0", 64'(exp_q0.size()), 64'd0);
    chk("drain_q1", 64'(exp_q1.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
